bcd_digit_entry: RTL and testbench

//  Upstream operand-entry stage for the ALU's BCD-to-binary converter. Collects

---
 rtl/bcd_digit_entry_pkg.sv | 18 +
 rtl/bcd_digit_entry_shift_reg.sv | 35 +++
 rtl/bcd_digit_entry.sv | 120 ++++++++++++
 tb/tb_bcd_digit_entry.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/bcd_digit_entry_pkg.sv
// Shared definitions for the BCD operand-entry stage and the converter it feeds.
package bcd_digit_entry_pkg;

  localparam int          NDIGITS_DEF   = 2;
  localparam logic [3:0]  BCD_DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ENTRY = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // True for a decimal nibble.
  function automatic logic digit_ok(input logic [3:0] d);
    return d <= BCD_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_entry_shift_reg.sv
// NDIGITS x 4 shift register: new digit enters at the ones position, older
// digits move toward the MSD. load_zero wins over shift_en.
module bcd_digit_entry_shift_reg #(
  parameter int NDIGITS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_zero,
  input  logic                   shift_en,
  input  logic [3:0]             din,
  output logic [4*NDIGITS-1:0]   bcd
);

  logic [NDIGITS-1:0][3:0] dig_q;

  // One nibble register per digit position; position 0 takes the new digit.
  for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
    logic [3:0] src;
    if (g == 0) begin : g_src0
      assign src = din;
    end else begin : g_srcn
      assign src = dig_q[g-1];
    end

    // Clear on load_zero, otherwise shift when enabled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)            dig_q[g] <= 4'd0;
      else if (load_zero) dig_q[g] <= 4'd0;
      else if (shift_en)  dig_q[g] <= src;
    end
  end

  assign bcd = dig_q;

endmodule

// File: rtl/bcd_digit_entry.sv
// Operand-entry stage: collects decimal digits MSD-first into a packed BCD
// word and presents it with a valid/ready handshake after enter.
module bcd_digit_entry
  import bcd_digit_entry_pkg::*;
#(
  parameter int NDIGITS = NDIGITS_DEF,
  parameter int CNT_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            digit,
  input  logic                  digit_stb,
  input  logic                  enter,
  input  logic                  clear,
  output logic [4*NDIGITS-1:0]  BCD,
  output logic                  bcd_valid,
  input  logic                  bcd_ready,
  output logic [CNT_W-1:0]      digit_count,
  output logic                  err_digit,
  output logic                  err_full
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NDIGITS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_digit_q, err_digit_d;
  logic             err_full_q, err_full_d;
  logic             shift_en, load_zero;
  logic             good_stb, bad_stb, accept;

  assign good_stb = digit_stb &&  digit_ok(digit);
  assign bad_stb  = digit_stb && !digit_ok(digit);

  bcd_digit_entry_shift_reg #(.NDIGITS(NDIGITS)) u_sr (
    .clk       (clk),
    .rst       (rst),
    .load_zero (load_zero),
    .shift_en  (shift_en),
    .din       (digit),
    .bcd       (BCD)
  );

  // State, counter, valid and error-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      err_digit_q <= 1'b0;
      err_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      err_digit_q <= err_digit_d;
      err_full_q  <= err_full_d;
    end
  end

  // Next-state logic; clear overrides everything, including error reporting.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    err_digit_d = 1'b0;
    err_full_d  = 1'b0;
    shift_en    = 1'b0;
    load_zero   = 1'b0;
    accept      = 1'b0;

    if (clear) begin
      state_d   = ST_EMPTY;
      cnt_d     = '0;
      valid_d   = 1'b0;
      load_zero = 1'b1;
    end else begin
      err_digit_d = bad_stb;
      case (state_q)
        ST_EMPTY, ST_ENTRY: begin
          accept     = good_stb && (cnt_q < CNT_MAX);
          err_full_d = good_stb && (cnt_q == CNT_MAX);
          if (accept) begin
            shift_en = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
            state_d  = ST_ENTRY;
          end
          // A digit arriving with enter is part of the operand, so an
          // EMPTY+digit+enter cycle still presents a value.
          if (enter && (accept || cnt_q != '0)) begin
            state_d = ST_HOLD;
            valid_d = 1'b1;
          end
        end
        ST_HOLD: begin
          err_full_d = good_stb;
          if (valid_q && bcd_ready) begin
            state_d   = ST_EMPTY;
            cnt_d     = '0;
            valid_d   = 1'b0;
            load_zero = 1'b1;
          end
        end
        default: begin
          state_d   = ST_EMPTY;
          cnt_d     = '0;
          valid_d   = 1'b0;
          load_zero = 1'b1;
        end
      endcase
    end
  end

  assign bcd_valid   = valid_q;
  assign digit_count = cnt_q;
  assign err_digit   = err_digit_q;
  assign err_full    = err_full_q;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Directed bench for bcd_digit_entry: vector table plus async-reset and
// converter-chain sequences.
module tb_bcd_digit_entry;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit;
  logic       digit_stb, enter, clear, bcd_ready;
  logic [7:0] BCD;
  logic       bcd_valid;
  logic [1:0] digit_count;
  logic       err_digit, err_full;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_digit_entry #(.NDIGITS(2), .CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .digit       (digit),
    .digit_stb   (digit_stb),
    .enter       (enter),
    .clear       (clear),
    .BCD         (BCD),
    .bcd_valid   (bcd_valid),
    .bcd_ready   (bcd_ready),
    .digit_count (digit_count),
    .err_digit   (err_digit),
    .err_full    (err_full)
  );

  typedef struct {
    string      name;
    logic       stb;
    logic [3:0] dig;
    logic       ent;
    logic       clr;
    logic       rdy;
    logic [7:0] e_bcd;
    logic       e_vld;
    logic [1:0] e_cnt;
    logic       e_ed;
    logic       e_ef;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic s, input logic [3:0] d, input logic e,
                     input logic c, input logic r, input logic [7:0] b, input logic v,
                     input logic [1:0] k, input logic ed, input logic ef);
    vec_t t;
    t.name = n; t.stb = s; t.dig = d; t.ent = e; t.clr = c; t.rdy = r;
    t.e_bcd = b; t.e_vld = v; t.e_cnt = k; t.e_ed = ed; t.e_ef = ef;
    vecs.push_back(t);
  endtask

  // Apply one cycle of inputs; return #1 after the rising edge.
  task automatic step(input logic s, input logic [3:0] d, input logic e,
                      input logic c, input logic r);
    digit_stb = s; digit = d; enter = e; clear = c; bcd_ready = r;
    @(posedge clk); #1;
    digit_stb = 0; enter = 0; clear = 0; bcd_ready = 0;
  endtask

  task automatic chk_all(input string n, input logic [7:0] b, input logic v,
                         input logic [1:0] k, input logic ed, input logic ef);
    chk({n, ".bcd"},   32'(BCD),         32'(b));
    chk({n, ".valid"}, 32'(bcd_valid),   32'(v));
    chk({n, ".cnt"},   32'(digit_count), 32'(k));
    chk({n, ".errd"},  32'(err_digit),   32'(ed));
    chk({n, ".errf"},  32'(err_full),    32'(ef));
  endtask

  // Reference BCD-to-binary conversion standing in for the downstream converter.
  function automatic int bcd2bin(input logic [7:0] b);
    return 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  initial begin
    rst = 1'b1; digit = 0; digit_stb = 0; enter = 0; clear = 0; bcd_ready = 0;

    //   name        stb dig   ent clr rdy  bcd    vld cnt ed ef
    add("t1_d1",     1, 4'd1,  0, 0, 0,  8'h01, 0, 1, 0, 0);
    add("t1_d5",     1, 4'd5,  0, 0, 0,  8'h15, 0, 2, 0, 0);
    add("t1_ent",    0, 4'd0,  1, 0, 0,  8'h15, 1, 2, 0, 0);
    add("t1_xfer",   0, 4'd0,  0, 0, 1,  8'h00, 0, 0, 0, 0);
    add("t2_dF",     1, 4'hF,  0, 0, 0,  8'h00, 0, 0, 1, 0);
    add("t2_idle",   0, 4'd0,  0, 0, 0,  8'h00, 0, 0, 0, 0);
    add("t2_d1",     1, 4'd1,  0, 0, 0,  8'h01, 0, 1, 0, 0);
    add("t2_d5",     1, 4'd5,  0, 0, 0,  8'h15, 0, 2, 0, 0);
    add("t2_d9full", 1, 4'd9,  0, 0, 0,  8'h15, 0, 2, 0, 1);
    add("t2_idle2",  0, 4'd0,  0, 0, 0,  8'h15, 0, 2, 0, 0);
    add("t2_clr",    0, 4'd0,  0, 1, 0,  8'h00, 0, 0, 0, 0);
    add("t3_d7ent",  1, 4'd7,  1, 0, 0,  8'h07, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      add("t3_hold", 0, 4'd0,  0, 0, 0,  8'h07, 1, 1, 0, 0);
    add("t3_d3hold", 1, 4'd3,  0, 0, 0,  8'h07, 1, 1, 0, 1);
    add("t3_dFhold", 1, 4'hF,  0, 0, 0,  8'h07, 1, 1, 1, 0);
    add("t3_xfer",   0, 4'd0,  0, 0, 1,  8'h00, 0, 0, 0, 0);
    add("t4_d4",     1, 4'd4,  0, 0, 0,  8'h04, 0, 1, 0, 0);
    add("t4_d2",     1, 4'd2,  0, 0, 0,  8'h42, 0, 2, 0, 0);
    add("t4_ent",    0, 4'd0,  1, 0, 0,  8'h42, 1, 2, 0, 0);
    add("t4_clrrdy", 0, 4'd0,  0, 1, 1,  8'h00, 0, 0, 0, 0);
    add("t4_entemp", 0, 4'd0,  1, 0, 0,  8'h00, 0, 0, 0, 0);
    add("t4_entrdy", 0, 4'd0,  1, 0, 1,  8'h00, 0, 0, 0, 0);
    add("t4_d3",     1, 4'd3,  0, 0, 0,  8'h03, 0, 1, 0, 0);
    add("t4_clrdig", 1, 4'd4,  0, 1, 0,  8'h00, 0, 0, 0, 0);

    // Reset state
    #12;
    chk_all("reset", 8'h00, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all("post_reset", 8'h00, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].stb, vecs[i].dig, vecs[i].ent, vecs[i].clr, vecs[i].rdy);
      chk_all(vecs[i].name, vecs[i].e_bcd, vecs[i].e_vld, vecs[i].e_cnt,
              vecs[i].e_ed, vecs[i].e_ef);
    end

    // Async reset in the middle of HOLD
    step(1, 4'd6, 0, 0, 0);
    step(0, 4'd0, 1, 0, 0);
    chk_all("t5_hold", 8'h06, 1, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", 32'(bcd_valid), 32'd0);
    chk("t5_async_bcd",   32'(BCD),       32'd0);
    chk("t5_async_cnt",   32'(digit_count), 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    step(1, 4'd9, 0, 0, 0);
    step(1, 4'd9, 0, 0, 0);
    step(0, 4'd0, 1, 0, 0);
    chk_all("t5_99", 8'h99, 1, 2, 0, 0);
    step(0, 4'd0, 0, 0, 1);
    chk_all("t5_xfer", 8'h00, 0, 0, 0, 0);

    // Chain into the converter reference
    step(1, 4'd1, 0, 0, 0);
    step(1, 4'd5, 0, 0, 0);
    step(0, 4'd0, 1, 0, 0);
    chk("t6_bcd", 32'(BCD), 32'h15);
    chk("t6_conv", 32'(bcd2bin(BCD)), 32'd15);
    chk("t6_valid", 32'(bcd_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit 100000 reached");
    $fatal(1);
  end

endmodule
